button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 145 ++++++++++++++
 tb/tb_button_conditioner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchroniser, debouncer, long-press and aux reset pulse generator
// Optional BTN_IRQ_EN adds a sticky irq output with irq_clr.
module button_conditioner #(
    parameter int N_BTN             = 2,
    parameter int ACTIVE_LOW        = 1,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 150000000,
    parameter int RST_BTN           = 1,
    parameter int RST_PULSE_CYCLES  = 1000
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] long_press,
    output logic             aux_reset_n
`ifdef BTN_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_clr
`endif
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int PW   = $clog2(RST_PULSE_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]  LP_MAX     = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0]  LP_LAST    = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [N_BTN-1:0] RELEASED   = {N_BTN{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_REL
    } rst_state_t;

    logic [N_BTN-1:0] meta_ff;
    logic [N_BTN-1:0] sync_ff;
    logic [N_BTN-1:0] sync;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [LP_W-1:0]  lp_cnt [N_BTN];
    rst_state_t       state;
    rst_state_t       next_state;
    logic [PW-1:0]    pulse_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            meta_ff <= RELEASED;
            sync_ff <= RELEASED;
        end else begin
            meta_ff <= btn_raw;
            sync_ff <= meta_ff;
        end
    end

    assign sync = (ACTIVE_LOW != 0) ? ~sync_ff : sync_ff;

    // Level and its strobe update together when the disagreement has lasted DEBOUNCE_CYCLES.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;
                if (sync[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i]   <= sync[i];
                    btn_press[i]   <= sync[i];
                    btn_release[i] <= ~sync[i];
                    db_cnt[i]      <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            long_press <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                lp_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                long_press[i] <= btn_level[i] && (lp_cnt[i] == LP_LAST);
                if (!btn_level[i]) begin
                    lp_cnt[i] <= '0;
                end else if (lp_cnt[i] != LP_MAX) begin
                    lp_cnt[i] <= lp_cnt[i] + LP_W'(1);
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (long_press[RST_BTN]) next_state = ST_ASSERT;
            ST_ASSERT:   if (pulse_cnt == '0) next_state = ST_WAIT_REL;
            ST_WAIT_REL: if (!btn_level[RST_BTN]) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // aux_reset_n is decoded from next_state into a flop so the pin never glitches.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            pulse_cnt   <= '0;
            aux_reset_n <= 1'b1;
        end else begin
            state       <= next_state;
            aux_reset_n <= (next_state != ST_ASSERT);
            if (state == ST_IDLE && next_state == ST_ASSERT) begin
                pulse_cnt <= PULSE_LAST;
            end else if (state == ST_ASSERT && pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - PW'(1);
            end
        end
    end

`ifdef BTN_IRQ_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq <= 1'b0;
        end else begin
            irq <= (irq & ~irq_clr) | (|btn_press) | (|long_press);
        end
    end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic       aclk;
    logic       aresetn;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] long_press;
    logic       aux_reset_n;
`ifdef BTN_IRQ_EN
    logic       irq;
    logic       irq_clr;
`endif

    int checks;
    int errors;

    button_conditioner #(
        .N_BTN(2),
        .ACTIVE_LOW(1),
        .DEBOUNCE_CYCLES(8),
        .LONG_PRESS_CYCLES(100),
        .RST_BTN(1),
        .RST_PULSE_CYCLES(20)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .long_press(long_press),
        .aux_reset_n(aux_reset_n)
`ifdef BTN_IRQ_EN
        ,
        .irq(irq),
        .irq_clr(irq_clr)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge aclk);
    endtask

    task automatic test_reset;
        int bad;
        btn_raw = 2'b11;
        aresetn = 1'b0;
        tick(3);
        aresetn = 1'b1;
        tick(1);
        checks++; if (btn_level !== 2'b00) begin errors++; $display("FAIL reset_level got %b want 00", btn_level); end
        checks++; if (btn_press !== 2'b00) begin errors++; $display("FAIL reset_press got %b want 00", btn_press); end
        checks++; if (btn_release !== 2'b00) begin errors++; $display("FAIL reset_release got %b want 00", btn_release); end
        checks++; if (long_press !== 2'b00) begin errors++; $display("FAIL reset_long got %b want 00", long_press); end
        checks++; if (aux_reset_n !== 1'b1) begin errors++; $display("FAIL reset_aux got %b want 1", aux_reset_n); end
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if (aux_reset_n !== 1'b1 || btn_level !== 2'b00 || btn_press !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_idle_1000 got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_glitch;
        int changes;
        changes = 0;
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_release !== 2'b00) changes++;
        end
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_release !== 2'b00) changes++;
        end
        checks++; if (changes != 0) begin errors++; $display("FAIL glitch got %0d changed cycles want 0", changes); end
    endtask

    task automatic test_press_release;
        btn_raw[0] = 1'b0;
        tick(9);
        checks++; if (btn_level[0] !== 1'b0 || btn_press[0] !== 1'b0) begin errors++; $display("FAIL press_early level %b press %b want 0 0", btn_level[0], btn_press[0]); end
        tick(1);
        checks++; if (btn_level[0] !== 1'b1) begin errors++; $display("FAIL press_level got %b want 1", btn_level[0]); end
        checks++; if (btn_press !== 2'b01) begin errors++; $display("FAIL press_strobe got %b want 01", btn_press); end
        tick(1);
        checks++; if (btn_press !== 2'b00) begin errors++; $display("FAIL press_single got %b want 00", btn_press); end
        tick(10);
        btn_raw[0] = 1'b1;
        tick(9);
        checks++; if (btn_level[0] !== 1'b1 || btn_release[0] !== 1'b0) begin errors++; $display("FAIL release_early level %b rel %b want 1 0", btn_level[0], btn_release[0]); end
        tick(1);
        checks++; if (btn_level[0] !== 1'b0 || btn_release !== 2'b01) begin errors++; $display("FAIL release_strobe level %b rel %b want 0 01", btn_level[0], btn_release); end
        checks++; if (btn_press !== 2'b00) begin errors++; $display("FAIL release_no_press got %b want 00", btn_press); end
        tick(1);
        checks++; if (btn_release !== 2'b00) begin errors++; $display("FAIL release_single got %b want 00", btn_release); end
        tick(5);
    endtask

    // Hold ch1 for n cycles from now; the level, long-press and pulse timing are measured in sample ticks.
    task automatic measure_hold(input string tag, input int n);
        int lvl_at, lp_at, lp_cnt_seen, low_cnt, first_low;
        lvl_at = -1; lp_at = -1; lp_cnt_seen = 0; low_cnt = 0; first_low = -1;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            if (btn_level[1] === 1'b1 && lvl_at < 0) lvl_at = k;
            if (long_press[1] === 1'b1) begin lp_cnt_seen++; if (lp_at < 0) lp_at = k; end
            if (aux_reset_n === 1'b0) begin low_cnt++; if (first_low < 0) first_low = k; end
        end
        checks++; if (lvl_at != 10) begin errors++; $display("FAIL %s level_cycle got %0d want 10", tag, lvl_at); end
        checks++; if (lp_cnt_seen != 1 || lp_at != 110) begin errors++; $display("FAIL %s long_press count %0d at %0d want 1 at 110", tag, lp_cnt_seen, lp_at); end
        checks++; if (low_cnt != 20) begin errors++; $display("FAIL %s aux_low_cycles got %0d want 20", tag, low_cnt); end
        checks++; if (first_low != 111) begin errors++; $display("FAIL %s aux_first_low got %0d want 111", tag, first_low); end
    endtask

    task automatic test_reset_pulse;
        btn_raw[1] = 1'b0;
        measure_hold("pulse", 300);
        btn_raw[1] = 1'b1;
        tick(12);
        checks++; if (btn_level[1] !== 1'b0 || aux_reset_n !== 1'b1) begin errors++; $display("FAIL pulse_released level %b aux %b want 0 1", btn_level[1], aux_reset_n); end
    endtask

    task automatic test_reset_mid_assert;
        int waited;
        btn_raw[1] = 1'b0;
        waited = 0;
        while (aux_reset_n !== 1'b0 && waited < 200) begin tick(1); waited++; end
        checks++; if (aux_reset_n !== 1'b0) begin errors++; $display("FAIL midrst_reach_assert aux %b after %0d cycles want 0", aux_reset_n, waited); end
        tick(5);
        aresetn = 1'b0;
        #1;
        checks++; if (aux_reset_n !== 1'b1) begin errors++; $display("FAIL midrst_aux got %b want 1", aux_reset_n); end
        checks++; if (btn_level !== 2'b00 || long_press !== 2'b00) begin errors++; $display("FAIL midrst_outputs level %b long %b want 00 00", btn_level, long_press); end
        tick(3);
        aresetn = 1'b1;
        measure_hold("midrst", 200);
        btn_raw[1] = 1'b1;
        tick(15);
    endtask

`ifdef BTN_IRQ_EN
    task automatic test_irq;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        btn_raw[0] = 1'b0;
        tick(11);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        tick(5);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky got %b want 1", irq); end
        btn_raw[1] = 1'b0;
        tick(10);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", irq); end
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
        btn_raw = 2'b11;
        tick(15);
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        aresetn = 1'b0;
        btn_raw = 2'b11;
`ifdef BTN_IRQ_EN
        irq_clr = 1'b0;
`endif
        test_reset;
        test_glitch;
        test_press_release;
        test_reset_pulse;
        test_reset_mid_assert;
`ifdef BTN_IRQ_EN
        test_irq;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
